prog_loader: RTL

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/loader_pkg.sv | 15 +
 rtl/prog_loader_if.sv | 25 ++
 rtl/word_packer.sv | 34 +++
 rtl/prog_loader.sv | 91 +++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared definitions for the program loader: FSM states and image geometry.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CHECK,
    DONE,
    ERR
  } loaderState_t;

  localparam int WORD_BYTES = 4;
  localparam int MAX_WORDS  = 256;

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input and instruction-memory write bus of the program loader.
interface prog_loader_if;

  logic        i_valid;
  logic [7:0]  i_byte;
  logic        o_ready;
  logic        i_start;
  logic        o_we;
  logic [7:0]  o_waddr;
  logic [31:0] o_wdata;
  logic        o_cpu_rst_n;
  logic        o_done;
  logic        o_err;

  modport master (
    output i_valid, i_byte, i_start,
    input  o_ready, o_we, o_waddr, o_wdata, o_cpu_rst_n, o_done, o_err
  );

  modport slave (
    input  i_valid, i_byte, i_start,
    output o_ready, o_we, o_waddr, o_wdata, o_cpu_rst_n, o_done, o_err
  );

endinterface

// File: rtl/word_packer.sv
// Packs a byte stream big-endian into 32-bit words; flags the byte that completes a word.
module word_packer
  import loader_pkg::*;
(
  input  logic        clock,
  input  logic        rstN,
  input  logic        clear,
  input  logic        shiftEn,
  input  logic [7:0]  byteIn,
  output logic [31:0] packedWord,
  output logic        wordComplete
);

  logic [23:0] shiftReg;
  logic [1:0]  byteCnt;

  // The completing byte is appended combinationally so the word is ready in the same cycle.
  assign wordComplete = shiftEn && (byteCnt == 2'(WORD_BYTES - 1));
  assign packedWord   = {shiftReg, byteIn};

  always_ff @(posedge clock or negedge rstN) begin
    if (!rstN) begin
      shiftReg <= '0;
      byteCnt  <= '0;
    end else if (clear) begin
      shiftReg <= '0;
      byteCnt  <= '0;
    end else if (shiftEn) begin
      shiftReg <= {shiftReg[15:0], byteIn};
      byteCnt  <= byteCnt + 2'd1;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Streams a length-prefixed, XOR-checksummed program image into instruction memory
// and holds the CPU in reset until a good image has been loaded.
module prog_loader
  import loader_pkg::*;
(
  input  logic         i_clk,
  input  logic         i_rst_n,
  prog_loader_if.slave bus
);

  loaderState_t state, stateNext;

  logic        accept;
  logic        packClear;
  logic        packShift;
  logic        wordComplete;
  logic [31:0] packedWord;
  logic [7:0]  wordIdx;
  logic [7:0]  lastIdx;
  logic [7:0]  checksum;
  logic        we;
  logic [7:0]  wAddr;
  logic [31:0] wData;

  assign accept    = bus.i_valid & bus.o_ready;
  assign packClear = (state == IDLE) & accept;
  assign packShift = (state == LOAD) & accept;

  word_packer uPacker (
    .clock        (i_clk),
    .rstN         (i_rst_n),
    .clear        (packClear),
    .shiftEn      (packShift),
    .byteIn       (bus.i_byte),
    .packedWord   (packedWord),
    .wordComplete (wordComplete)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:     if (accept) stateNext = LOAD;
      LOAD:     if (wordComplete && (wordIdx == lastIdx)) stateNext = CHECK;
      CHECK:    if (accept) stateNext = (bus.i_byte == checksum) ? DONE : ERR;
      DONE, ERR: if (bus.i_start) stateNext = IDLE;
      default:  stateNext = IDLE;
    endcase
  end

  // A count byte of 0 gives lastIdx 255, so the 8-bit word index covers all 256 words.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wordIdx  <= '0;
      lastIdx  <= '0;
      checksum <= '0;
      we       <= 1'b0;
      wAddr    <= '0;
      wData    <= '0;
    end else begin
      we <= 1'b0;
      if (packClear) begin
        wordIdx  <= '0;
        checksum <= '0;
        lastIdx  <= bus.i_byte - 8'd1;
      end
      if (packShift) begin
        checksum <= checksum ^ bus.i_byte;
        if (wordComplete) begin
          we      <= 1'b1;
          wAddr   <= wordIdx;
          wData   <= packedWord;
          wordIdx <= wordIdx + 8'd1;
        end
      end
    end
  end

  assign bus.o_ready     = i_rst_n & ((state == IDLE) | (state == LOAD) | (state == CHECK));
  assign bus.o_we        = we;
  assign bus.o_waddr     = wAddr;
  assign bus.o_wdata     = wData;
  assign bus.o_cpu_rst_n = (state == DONE);
  assign bus.o_done      = (state == DONE);
  assign bus.o_err       = (state == ERR);

endmodule
